// File: rtl/ddr3_b0_wr_burst.sv
// Bank0 DDR3 write stage: stages 128-bit pixel words into the write-data FIFO and issues one write command per burst.
// Latency: data strobe 1 cycle after the input handshake; command strobe at least 1 cycle after the burst's last data strobe.
// Backpressure: in_ready low outside FILL or while the data FIFO is full; commands hold while the command FIFO is full.
module ddr3_b0_wr_burst #(
   parameter int          BURST_LEN    = 64,
   parameter logic [27:0] BASE_ADDR    = 28'h0,
   parameter int          FRAME_BURSTS = 1536,
   parameter int          BEAT_BYTES   = 16
) (
   input  logic         sclk,
   input  logic         rst,
   input  logic         ddr3_init_complete,
   input  logic         enable,
   input  logic         frame_start,
   input  logic         in_valid,
   input  logic [127:0] in_data,
   output logic         in_ready,
   output logic         b0_wr_cmd_clk,
   output logic         b0_wr_cmd_en,
   output logic [5:0]   b0_wr_cmd_bl,
   output logic [27:0]  b0_wr_cmd_byte_addr,
   input  logic         b0_wr_cmd_empty,
   input  logic         b0_wr_cmd_full,
   output logic         b0_wr_data_clk,
   output logic         b0_wr_data_en,
   output logic [127:0] b0_wr_data_data,
   output logic [15:0]  b0_wr_data_mask,
   input  logic         b0_wr_data_full,
   input  logic         b0_wr_data_empty,
   input  logic [6:0]   b0_wr_data_count,
   output logic         frame_done,
   output logic         busy
);

   localparam int             BCW         = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
   localparam logic [27:0]    ADDR_STRIDE = 28'(BURST_LEN * BEAT_BYTES);
   localparam logic [6:0]     LAST_BEAT   = 7'(BURST_LEN - 1);
   localparam logic [BCW-1:0] LAST_BURST  = BCW'(FRAME_BURSTS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_CMD   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [6:0]     r_beat_cnt;
   logic [BCW-1:0] r_burst_cnt;
   logic [27:0]    r_addr;
   logic           r_cmd_en;
   logic           r_data_en;
   logic [127:0]   r_data;
   logic           r_frame_done;
   logic           r_pending;

   logic           w_in_ready;
   logic           w_issue;
   logic           w_hs;
   logic           w_last_beat;
   logic           w_fs_now;
   logic           w_fs_defer;
   logic           w_unused;

   // Status inputs kept on the port list for the controller interface but not needed here.
   assign w_unused = ^{b0_wr_cmd_empty, b0_wr_data_count};

   assign w_hs        = in_valid & w_in_ready;
   assign w_last_beat = (r_beat_cnt == LAST_BEAT);

   // A restart between bursts takes effect at once; one arriving inside a burst waits for that burst's command.
   assign w_fs_now   = frame_start & ((r_state == S_IDLE) || (r_state == S_DRAIN) ||
                                      ((r_state == S_FILL) && (r_beat_cnt == 7'd0)));
   assign w_fs_defer = frame_start & ~w_fs_now;

   assign in_ready            = w_in_ready;
   assign b0_wr_cmd_clk       = sclk;
   assign b0_wr_data_clk      = sclk;
   assign b0_wr_cmd_en        = r_cmd_en;
   assign b0_wr_cmd_bl        = 6'(BURST_LEN - 1);
   assign b0_wr_cmd_byte_addr = r_addr;
   assign b0_wr_data_en       = r_data_en;
   assign b0_wr_data_data     = r_data;
   assign b0_wr_data_mask     = 16'h0000;
   assign frame_done          = r_frame_done;
   assign busy                = (r_state != S_IDLE);

   // State register.
   always_ff @(posedge sclk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, input acceptance and command-issue decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ddr3_init_complete && enable) begin
               w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            w_in_ready = ~b0_wr_data_full;
            if (in_valid && !b0_wr_data_full && w_last_beat) begin
               w_state_nxt = S_CMD;
            end
         end
         S_CMD: begin
            if (!b0_wr_cmd_full) begin
               w_issue     = 1'b1;
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Hold off the next burst until the controller has taken every word of this one.
            if (b0_wr_data_empty) begin
               w_state_nxt = (enable && ddr3_init_complete) ? S_FILL : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Beat counter and the one-cycle data pipeline into the write-data FIFO.
   always_ff @(posedge sclk) begin
      if (rst) begin
         r_beat_cnt <= 7'd0;
         r_data_en  <= 1'b0;
         r_data     <= 128'd0;
      end else begin
         r_data_en <= w_hs;
         if (w_hs) begin
            r_data     <= in_data;
            r_beat_cnt <= w_last_beat ? 7'd0 : (r_beat_cnt + 7'd1);
         end
      end
   end

   // Command strobe: a single registered pulse leaving CMD, so it trails the last data strobe.
   always_ff @(posedge sclk) begin
      if (rst) begin
         r_cmd_en <= 1'b0;
      end else begin
         r_cmd_en <= w_issue;
      end
   end

   // Frame address, burst count, deferred restart and end-of-frame pulse.
   always_ff @(posedge sclk) begin
      if (rst) begin
         r_addr       <= BASE_ADDR;
         r_burst_cnt  <= '0;
         r_pending    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (r_cmd_en) begin
            // The strobe cycle: the address shown with it is consumed, so move to the next burst.
            r_pending <= 1'b0;
            if (r_pending || frame_start) begin
               r_addr      <= BASE_ADDR;
               r_burst_cnt <= '0;
            end else if (r_burst_cnt == LAST_BURST) begin
               r_addr       <= BASE_ADDR;
               r_burst_cnt  <= '0;
               r_frame_done <= 1'b1;
            end else begin
               r_addr      <= r_addr + ADDR_STRIDE;
               r_burst_cnt <= r_burst_cnt + 1'b1;
            end
         end else if (w_fs_now) begin
            r_addr      <= BASE_ADDR;
            r_burst_cnt <= '0;
         end else if (w_fs_defer) begin
            r_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ddr3_b0_wr_burst.sv
// Bench for ddr3_b0_wr_burst: directed bursts checked against a frame-level model and literal expectations.
// Latency: observes outputs on the falling edge, one model step per clock.
// Backpressure: drives command/data FIFO full flags directly from the stimulus.
module tb_ddr3_b0_wr_burst;

   localparam int NB = 4;

   logic         sclk;
   logic         rst;
   logic         ddr3_init_complete;
   logic         enable;
   logic         frame_start;
   logic         in_valid;
   logic [127:0] in_data;
   logic         in_ready;
   logic         b0_wr_cmd_clk;
   logic         b0_wr_cmd_en;
   logic [5:0]   b0_wr_cmd_bl;
   logic [27:0]  b0_wr_cmd_byte_addr;
   logic         b0_wr_cmd_empty;
   logic         b0_wr_cmd_full;
   logic         b0_wr_data_clk;
   logic         b0_wr_data_en;
   logic [127:0] b0_wr_data_data;
   logic [15:0]  b0_wr_data_mask;
   logic         b0_wr_data_full;
   logic         b0_wr_data_empty;
   logic [6:0]   b0_wr_data_count;
   logic         frame_done;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   // model state
   logic [127:0] m_q[$];
   int           m_beats_in  = 0;
   int           m_beats_out = 0;
   int           m_idx       = 0;
   bit           m_pending   = 0;
   bit           m_exp_fd    = 0;
   int           cyc         = 0;
   int           de_total    = 0;
   int           de_first    = -1;
   int           de_last     = -1;
   int           cmd_total   = 0;
   int           fd_total    = 0;

   ddr3_b0_wr_burst #(
      .BURST_LEN    (64),
      .BASE_ADDR    (28'h0),
      .FRAME_BURSTS (NB),
      .BEAT_BYTES   (16)
   ) dut (
      .sclk                (sclk),
      .rst                 (rst),
      .ddr3_init_complete  (ddr3_init_complete),
      .enable              (enable),
      .frame_start         (frame_start),
      .in_valid            (in_valid),
      .in_data             (in_data),
      .in_ready            (in_ready),
      .b0_wr_cmd_clk       (b0_wr_cmd_clk),
      .b0_wr_cmd_en        (b0_wr_cmd_en),
      .b0_wr_cmd_bl        (b0_wr_cmd_bl),
      .b0_wr_cmd_byte_addr (b0_wr_cmd_byte_addr),
      .b0_wr_cmd_empty     (b0_wr_cmd_empty),
      .b0_wr_cmd_full      (b0_wr_cmd_full),
      .b0_wr_data_clk      (b0_wr_data_clk),
      .b0_wr_data_en       (b0_wr_data_en),
      .b0_wr_data_data     (b0_wr_data_data),
      .b0_wr_data_mask     (b0_wr_data_mask),
      .b0_wr_data_full     (b0_wr_data_full),
      .b0_wr_data_empty    (b0_wr_data_empty),
      .b0_wr_data_count    (b0_wr_data_count),
      .frame_done          (frame_done),
      .busy                (busy)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_to(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
   endtask

   // Frame-level model: every accepted word must reappear in order, one command per 64 beats,
   // addresses step by 1 KiB through NB bursts, restarts honoured at the burst boundary.
   initial begin
      logic [127:0] w;
      @(posedge sclk);
      forever begin
         @(negedge sclk);
         cyc++;
         chk("frame_done", frame_done, m_exp_fd);
         m_exp_fd = 0;
         if (frame_done === 1'b1) fd_total++;
         chk("in_ready_rule", in_ready & (b0_wr_data_full | (m_beats_in >= 64)), 1'b0);
         if (b0_wr_data_en === 1'b1) begin
            if (m_q.size() == 0) begin
               fail_to("data_underflow");
            end else begin
               w = m_q.pop_front();
               chk("wr_data", b0_wr_data_data, w);
            end
            m_beats_out++;
            de_total++;
            if (de_first < 0) de_first = cyc;
            de_last = cyc;
         end
         if (frame_start === 1'b1) begin
            if (m_beats_in > 0) m_pending = 1;
            else m_idx = 0;
         end
         if (b0_wr_cmd_en === 1'b1) begin
            chk("cmd_addr", b0_wr_cmd_byte_addr, 128'(m_idx * 1024));
            chk("cmd_beats", m_beats_out, 64);
            chk("cmd_data_overlap", b0_wr_data_en, 1'b0);
            chk("cmd_bl", b0_wr_cmd_bl, 63);
            if (m_pending) begin
               m_idx = 0;
            end else if (m_idx == NB - 1) begin
               m_idx    = 0;
               m_exp_fd = 1;
            end else begin
               m_idx++;
            end
            m_pending   = 0;
            m_beats_in  = 0;
            m_beats_out = 0;
            cmd_total++;
         end
         if (in_valid && in_ready === 1'b1 && !rst) begin
            m_q.push_back(in_data);
            m_beats_in++;
         end
         if (rst) begin
            m_q.delete();
            m_beats_in  = 0;
            m_beats_out = 0;
            m_idx       = 0;
            m_pending   = 0;
            m_exp_fd    = 0;
         end
      end
   end

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_cmd_en"}, b0_wr_cmd_en, 1'b0);
      chk({nm, "_data_en"}, b0_wr_data_en, 1'b0);
      chk({nm, "_data"}, b0_wr_data_data, 128'd0);
      chk({nm, "_addr"}, b0_wr_cmd_byte_addr, 28'h0);
      chk({nm, "_in_ready"}, in_ready, 1'b0);
      chk({nm, "_frame_done"}, frame_done, 1'b0);
      chk({nm, "_busy"}, busy, 1'b0);
   endtask

   // Push one 64-word burst; optional mid-burst frame_start, data-full window or reset.
   task automatic send(input int tag, input int fs_beat, input int full_beat,
                       input int full_len, input int rst_beat);
      int n;
      bit stop;
      stop = 0;
      @(posedge sclk); #1;
      for (int i = 0; i < 64 && !stop; i++) begin
         if (i == rst_beat) begin
            in_valid = 0;
            rst = 1;
            @(posedge sclk); #1;
            rst = 0;
            @(negedge sclk);
            chk_reset_outputs("t6_rst");
            stop = 1;
         end else begin
            in_valid    = 1;
            in_data     = {32'(tag), 64'd0, 32'(i)};
            frame_start = (i == fs_beat);
            if (i == full_beat) begin
               b0_wr_data_full = 1;
               for (int k = 0; k < full_len; k++) begin
                  @(negedge sclk);
                  chk("t5_rdy_full", in_ready, 1'b0);
                  @(posedge sclk); #1;
                  frame_start = 0;
               end
               b0_wr_data_full = 0;
            end
            n = 0;
            @(negedge sclk);
            while (in_ready !== 1'b1 && n < 300) begin
               @(negedge sclk);
               n++;
            end
            if (n >= 300) begin
               fail_to("in_ready_wait");
               stop = 1;
            end
            @(posedge sclk); #1;
            frame_start = 0;
         end
      end
      in_valid = 0;
   endtask

   task automatic wait_cmd(input logic [27:0] exp_addr, input string nm);
      int n;
      n = 0;
      @(negedge sclk);
      while (b0_wr_cmd_en !== 1'b1 && n < 300) begin
         @(negedge sclk);
         n++;
      end
      if (n >= 300) begin
         fail_to(nm);
      end else begin
         chk(nm, b0_wr_cmd_byte_addr, exp_addr);
      end
   endtask

   initial begin
      int snap;
      rst = 1; enable = 0; ddr3_init_complete = 0; frame_start = 0;
      in_valid = 0; in_data = '0;
      b0_wr_cmd_full = 0; b0_wr_cmd_empty = 1;
      b0_wr_data_full = 0; b0_wr_data_empty = 1; b0_wr_data_count = '0;

      repeat (3) @(posedge sclk);
      @(negedge sclk);
      chk_reset_outputs("reset");
      chk("reset_bl", b0_wr_cmd_bl, 6'd63);
      chk("reset_mask", b0_wr_data_mask, 16'h0000);
      @(posedge sclk); #1;
      rst = 0; enable = 1; ddr3_init_complete = 1;

      // 1: two plain bursts
      send(0, -1, -1, 0, -1);
      wait_cmd(28'h000_0000, "t1_cmd0");
      chk("t1_bl", b0_wr_cmd_bl, 6'd63);
      chk("t1_de_count", de_total, 64);
      chk("t1_de_consecutive", de_last - de_first, 63);
      send(1, -1, -1, 0, -1);
      wait_cmd(28'h000_0400, "t1_cmd1");

      // 2: command FIFO full holds the strobe
      b0_wr_cmd_full = 1;
      send(2, -1, -1, 0, -1);
      for (int k = 0; k < 10; k++) begin
         @(negedge sclk);
         chk("t2_cmd_held", b0_wr_cmd_en, 1'b0);
         chk("t2_rdy_held", in_ready, 1'b0);
         chk("t2_addr_held", b0_wr_cmd_byte_addr, 28'h800);
      end
      @(posedge sclk); #1;
      b0_wr_cmd_full = 0;
      @(negedge sclk);
      chk("t2_cmd_not_yet", b0_wr_cmd_en, 1'b0);
      @(negedge sclk);
      chk("t2_cmd_strobe", b0_wr_cmd_en, 1'b1);
      chk("t2_cmd_addr", b0_wr_cmd_byte_addr, 28'h800);

      // 3: frame wrap
      send(3, -1, -1, 0, -1);
      wait_cmd(28'h000_0C00, "t3_cmd3");
      @(negedge sclk);
      chk("t3_fd_pulse", frame_done, 1'b1);
      @(negedge sclk);
      chk("t3_fd_single", frame_done, 1'b0);
      chk("t3_fd_total", fd_total, 1);
      send(4, -1, -1, 0, -1);
      wait_cmd(28'h000_0000, "t3_cmd_wrap");
      send(5, -1, -1, 0, -1);
      wait_cmd(28'h000_0400, "t3_cmd_next");

      // 4: frame_start mid-burst at 0x800
      send(6, 20, -1, 0, -1);
      wait_cmd(28'h000_0800, "t4_cmd_cur");
      @(negedge sclk);
      chk("t4_no_fd", frame_done, 1'b0);
      send(7, -1, -1, 0, -1);
      wait_cmd(28'h000_0000, "t4_cmd_restart");
      chk("t4_fd_total", fd_total, 1);

      // 5: data FIFO full window mid-burst
      snap = de_total;
      send(8, -1, 30, 5, -1);
      wait_cmd(28'h000_0400, "t5_cmd");
      chk("t5_de_count", de_total - snap, 64);

      // 6: reset mid-burst
      send(9, -1, -1, 0, 40);
      snap = cmd_total;
      repeat (20) @(negedge sclk);
      chk("t6_no_cmd", cmd_total - snap, 0);
      send(10, -1, -1, 0, -1);
      wait_cmd(28'h000_0000, "t6_cmd_after");

      repeat (4) @(negedge sclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
